// File: rtl/adder_arbiter_if.sv
// Request/response/adder bundle between requesting units, the arbiter and the shared adder.
// The master side is the environment (requesters, response consumer, adder result).
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic [31:0]           add_out;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_out,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy, add_a, add_b
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_out,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy, add_a, add_b
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit adder among NUM_REQ requesters.
// state   | meaning
// IDLE    | pick next requester from ptr, handshake on req_ready
// ISSUE   | operands stable at adder inputs, adder samples them
// CAPTURE | adder result valid, loaded into rsp_data
// RESP    | response presented until rsp_ready
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt;
    logic [ID_W-1:0] ptr_nxt;
    logic            found;
    logic            grant;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = ID_W'(idx);
            end
        end
    end

    assign grant   = (state == IDLE) && found;
    assign ptr_nxt = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so no handshake is seen while reset is held
    always_comb begin
        bus.req_ready = '0;
        if (grant && rst_n) bus.req_ready[gnt] = 1'b1;
        bus.busy      = (state != IDLE);
        bus.rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            bus.add_a    <= '0;
            bus.add_b    <= '0;
            bus.rsp_id   <= '0;
            bus.rsp_data <= '0;
        end else begin
            if (grant) begin
                bus.add_a  <= bus.req_a[32*int'(gnt) +: 32];
                bus.add_b  <= bus.req_b[32*int'(gnt) +: 32];
                bus.rsp_id <= gnt;
                ptr        <= ptr_nxt;
            end
            if (state == CAPTURE) bus.rsp_data <= bus.add_out;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter; models the shared registered adder locally.
module tb_adder_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    adder_arbiter_if #(.NUM_REQ(4)) bus ();

    adder_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // shared adder: one-cycle registered sum
    always @(posedge clk) bus.add_out <= bus.add_a + bus.add_b;

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    task automatic test_reset;
        @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready);
        end
        checks++;
        if ({bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b vld=%b id=%0d data=%h exp all 0",
                     bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        checks++;
        if ({bus.add_a, bus.add_b} !== 64'd0) begin
            failures++; $display("FAIL reset_add_ops got a=%h b=%h exp 0", bus.add_a, bus.add_b);
        end
        @(negedge clk);
        bus.req_valid = 4'h0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_release_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_contention;
        logic [3:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_op(i, 32'(i), 32'd100);
        bus.req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            exp_rdy = 4'b0001 << (n % 4);
            #1;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                failures++; $display("FAIL contention_grant%0d got=%b exp=%b", n, bus.req_ready, exp_rdy);
            end
            @(negedge clk);
            if (n == 4) bus.req_valid = 4'h0;
            #1;
            checks++;
            if ({bus.busy, bus.req_ready} !== 5'b1_0000) begin
                failures++;
                $display("FAIL contention_holdoff%0d got busy=%b rdy=%b exp busy=1 rdy=0000",
                         n, bus.busy, bus.req_ready);
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 2'(n % 4), 32'd100 + 32'(n % 4)}) begin
                failures++;
                $display("FAIL contention_rsp%0d got vld=%b id=%0d data=%0d exp vld=1 id=%0d data=%0d",
                         n, bus.rsp_valid, bus.rsp_id, bus.rsp_data, n % 4, 100 + n % 4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single;
        set_op(0, 32'd5, 32'd7);
        bus.req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.rsp_valid} !== 2'b10) begin
            failures++; $display("FAIL single_early got busy=%b vld=%b exp busy=1 vld=0", bus.busy, bus.rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 2'd0, 32'd12}) begin
            failures++;
            $display("FAIL single_rsp got vld=%b id=%0d data=%0d exp vld=1 id=0 data=12",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
            failures++; $display("FAIL single_done got busy=%b vld=%b exp 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0002);
        bus.req_valid = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            failures++; $display("FAIL wrap_ready got=%b exp=0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 2'd1, 32'h0000_0001}) begin
            failures++;
            $display("FAIL wrap_rsp got vld=%b id=%0d data=%h exp vld=1 id=1 data=00000001",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        @(negedge clk);
        set_op(2, 32'd1, 32'd2);
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL rr_first got=%b exp=0100", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        set_op(1, 32'd10, 32'd1);
        set_op(3, 32'd20, 32'd3);
        bus.req_valid = 4'b1010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            failures++; $display("FAIL rr_three_first got=%b exp=1000", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 2'd3, 32'd23}) begin
            failures++;
            $display("FAIL rr_rsp3 got vld=%b id=%0d data=%0d exp vld=1 id=3 data=23",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            failures++; $display("FAIL rr_one_second got=%b exp=0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 2'd1, 32'd11}) begin
            failures++;
            $display("FAIL rr_rsp1 got vld=%b id=%0d data=%0d exp vld=1 id=1 data=11",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        set_op(2, 32'd10, 32'd20);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL bp_grant got=%b exp=0100", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, bus.busy} !==
                {1'b1, 2'd2, 32'd30, 4'b0000, 1'b1}) begin
                failures++;
                $display("FAIL bp_hold%0d got vld=%b id=%0d data=%0d rdy=%b busy=%b exp 1 2 30 0000 1",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, bus.busy);
            end
            if (i == 4) begin
                bus.rsp_ready = 1'b1;
                bus.req_valid = 4'h0;
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
            failures++; $display("FAIL bp_release got busy=%b vld=%b exp 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        set_op(3, 32'd1, 32'd1);
        bus.req_valid = 4'b1000;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            failures++; $display("FAIL mid_grant got=%b exp=1000", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        checks++;
        if ({bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.add_a, bus.add_b, bus.req_ready} !== 104'd0) begin
            failures++;
            $display("FAIL mid_async_reset got busy=%b vld=%b id=%0d data=%h a=%h b=%h rdy=%b exp all 0",
                     bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.add_a, bus.add_b, bus.req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.rsp_valid, bus.req_ready} !== 5'b0) begin
                failures++;
                $display("FAIL mid_no_rsp%0d got vld=%b rdy=%b exp 0 0000", i, bus.rsp_valid, bus.req_ready);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_op(0, 32'd3, 32'd4);
        bus.req_valid = 4'b1001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL mid_ptr_zero got=%b exp=0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 2'd0, 32'd7}) begin
            failures++;
            $display("FAIL mid_next_rsp got vld=%b id=%0d data=%0d exp vld=1 id=0 data=7",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 4'h0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        test_reset;
        test_contention;
        test_single;
        test_wrap;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
